// File: rtl/as_jtag_mem_loader_pkg.sv
// Shared types and chain field offsets for the JTAG memory loader.
package as_pack;

    typedef enum logic [1:0] {
        CMD_NOP      = 2'd0,
        CMD_SET_ADDR = 2'd1,
        CMD_WRITE    = 2'd2,
        CMD_READ     = 2'd3
    } jtag_mem_cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_STB  = 2'd1,
        RD_STB  = 2'd2,
        RD_WAIT = 2'd3
    } loader_state_t;

    localparam int CMD_LSB   = 0;
    localparam int CMD_WIDTH = 2;
    localparam int SEL_LSB   = CMD_LSB + CMD_WIDTH;

    function automatic int sel_width_of(input int nr_targets);
        return (nr_targets > 1) ? $clog2(nr_targets) : 1;
    endfunction

    function automatic int addr_lsb(input int sel_width);
        return SEL_LSB + sel_width;
    endfunction

    function automatic int data_lsb(input int sel_width, input int addr_width);
        return addr_lsb(sel_width) + addr_width;
    endfunction

endpackage

// File: rtl/as_jtag_mem_loader_if.sv
// Memory-side bus between the loader and its attached target memories.
interface as_jtag_mem_loader_if #(
    parameter int addr_width = 10,
    parameter int data_width = 32,
    parameter int nr_targets = 2
);
    logic [addr_width-1:0]            mem_addr_o;
    logic [data_width-1:0]            mem_wdata_o;
    logic [nr_targets-1:0]            mem_we_o;
    logic [nr_targets-1:0]            mem_re_o;
    logic [nr_targets*data_width-1:0] mem_rdata_i;
    logic                             mux_sel_o;

    modport master (
        output mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o, mux_sel_o,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o, mux_sel_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/as_jtag_dr_shift.sv
// JTAG data register: capture/shift chain plus the update-edge latch of the data field.
module as_jtag_dr_shift #(
    parameter int chain_len = 45,
    parameter int upd_lsb   = 13
) (
    input  logic                         tck,
    input  logic                         tap_rst_s,
    input  logic                         dr_shift,
    input  logic                         dr_clock,
    input  logic                         dr_upd,
    input  logic                         ser_in,
    input  logic [chain_len-1:0]         capture_data,
    output logic                         ser_out,
    output logic                         upd_edge,
    output logic [upd_lsb-1:0]           ctrl_fields,
    output logic [chain_len-upd_lsb-1:0] upd_data
);
    logic [chain_len-1:0]         chain_r;
    logic [chain_len-upd_lsb-1:0] upd_r;
    logic                         upd_q;

    assign upd_edge    = dr_upd & ~upd_q;
    assign ser_out     = chain_r[0];
    assign ctrl_fields = chain_r[upd_lsb-1:0];
    assign upd_data    = upd_r;

    // Chain capture/shift, update-level history and data-field latch.
    always_ff @(posedge tck or posedge tap_rst_s) begin
        if (tap_rst_s) begin
            chain_r <= '0;
            upd_r   <= '0;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= dr_upd;
            if (dr_clock && !dr_shift) begin
                chain_r <= capture_data;
            end else if (dr_clock && dr_shift) begin
                chain_r <= {ser_in, chain_r[chain_len-1:1]};
            end else begin
                chain_r <= chain_r;
            end
            if (upd_edge) begin
                upd_r <= chain_r[chain_len-1:upd_lsb];
            end else begin
                upd_r <= upd_r;
            end
        end
    end
endmodule

// File: rtl/as_jtag_mem_loader.sv
// TCK-domain memory access port: decodes DR commands and drives reads/writes into nr_targets memories.
module as_jtag_mem_loader
    import as_pack::*;
#(
    parameter int addr_width = 10,
    parameter int data_width = 32,
    parameter int nr_targets = 2,
    parameter int rd_latency = 1
) (
    input  logic                 tck_i,
    input  logic                 tap_rst_s,
    input  logic                 dr_shift_i,
    input  logic                 dr_clock_i,
    input  logic                 dr_upd_i,
    input  logic                 ser_i,
    output logic                 ser_o,
    output logic                 busy_o,
    as_jtag_mem_loader_if.master mem
);
    localparam int sel_width = sel_width_of(nr_targets);
    localparam int chain_len = 2 + sel_width + addr_width + data_width;
    localparam int addr_lo   = addr_lsb(sel_width);
    localparam int data_lo   = data_lsb(sel_width, addr_width);
    localparam logic [sel_width:0] nr_targets_w = (sel_width+1)'(nr_targets);
    localparam logic [1:0] last_wait = 2'(rd_latency - 1);

    loader_state_t         state_r, state_nxt_s;
    jtag_mem_cmd_t         cmd_s;
    logic [data_lo-1:0]    ctrl_s;
    logic [data_width-1:0] upd_data_s;
    logic [chain_len-1:0]  cap_s;
    logic [sel_width-1:0]  sel_f_s, sel_r, sel_cap_s;
    logic [addr_width-1:0] addr_f_s, ptr_r;
    logic [data_width-1:0] rd_data_r, sel_rdata_s;
    logic [nr_targets-1:0] sel_onehot_s, we_r, re_r;
    logic [1:0]            wait_cnt_r;
    logic upd_edge_s, sel_ok_s, err_r, wrap_r, rd_valid_r, mux_sel_r, busy_r;
    logic set_addr_s, err_set_s, flag_clr_s, rd_issue_s, rd_done_s, ptr_inc_s;

    as_jtag_dr_shift #(.chain_len(chain_len), .upd_lsb(data_lo)) u_dr (
        .tck(tck_i), .tap_rst_s(tap_rst_s), .dr_shift(dr_shift_i), .dr_clock(dr_clock_i),
        .dr_upd(dr_upd_i), .ser_in(ser_i), .capture_data(cap_s), .ser_out(ser_o),
        .upd_edge(upd_edge_s), .ctrl_fields(ctrl_s), .upd_data(upd_data_s)
    );

    assign cmd_s    = jtag_mem_cmd_t'(ctrl_s[CMD_LSB +: CMD_WIDTH]);
    assign sel_f_s  = ctrl_s[SEL_LSB +: sel_width];
    assign addr_f_s = ctrl_s[addr_lo +: addr_width];
    assign sel_ok_s = ({1'b0, sel_f_s} < nr_targets_w);
    assign cap_s    = {rd_data_r, ptr_r, sel_cap_s, err_r, rd_valid_r};

    assign mem.mem_addr_o  = ptr_r;
    assign mem.mem_wdata_o = upd_data_s;
    assign mem.mem_we_o    = we_r;
    assign mem.mem_re_o    = re_r;
    assign mem.mux_sel_o   = mux_sel_r;
    assign busy_o          = busy_r;

    // Wrap flag is only reported when the select field has a spare MSB.
    always_comb begin
        sel_cap_s = sel_r;
        if (sel_width > 1) begin
            sel_cap_s[sel_width-1] = wrap_r;
        end else begin
            sel_cap_s = sel_r;
        end
    end

    // Target decode: one-hot strobe mask and read-data select.
    always_comb begin
        sel_onehot_s = '0;
        sel_rdata_s  = '0;
        for (int k = 0; k < nr_targets; k++) begin
            if (sel_r == sel_width'(k)) begin
                sel_onehot_s[k] = 1'b1;
                sel_rdata_s     = mem.mem_rdata_i[k*data_width +: data_width];
            end else begin
                sel_onehot_s[k] = 1'b0;
            end
        end
    end

    // Next-state and command decode; any update edge outside IDLE is an error.
    always_comb begin
        state_nxt_s = state_r;
        set_addr_s  = 1'b0;
        err_set_s   = 1'b0;
        flag_clr_s  = 1'b0;
        rd_issue_s  = 1'b0;
        rd_done_s   = 1'b0;
        ptr_inc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (upd_edge_s) begin
                    case (cmd_s)
                        CMD_NOP:      flag_clr_s = 1'b1;
                        CMD_SET_ADDR: begin
                            if (sel_ok_s) begin
                                set_addr_s = 1'b1;
                            end else begin
                                err_set_s = 1'b1;
                            end
                        end
                        CMD_WRITE:    state_nxt_s = WR_STB;
                        CMD_READ: begin
                            state_nxt_s = RD_STB;
                            rd_issue_s  = 1'b1;
                        end
                        default:      state_nxt_s = IDLE;
                    endcase
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR_STB: begin
                state_nxt_s = IDLE;
                ptr_inc_s   = 1'b1;
                err_set_s   = upd_edge_s;
            end
            RD_STB: begin
                state_nxt_s = RD_WAIT;
                err_set_s   = upd_edge_s;
            end
            RD_WAIT: begin
                err_set_s = upd_edge_s;
                if (wait_cnt_r == last_wait) begin
                    state_nxt_s = IDLE;
                    rd_done_s   = 1'b1;
                    ptr_inc_s   = 1'b1;
                end else begin
                    state_nxt_s = RD_WAIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, pointer, sticky flags, read-back data and registered strobes.
    always_ff @(posedge tck_i or posedge tap_rst_s) begin
        if (tap_rst_s) begin
            state_r    <= IDLE;
            wait_cnt_r <= 2'd0;
            ptr_r      <= '0;
            sel_r      <= '0;
            err_r      <= 1'b0;
            wrap_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
            we_r       <= '0;
            re_r       <= '0;
            mux_sel_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= (state_r == RD_WAIT) ? wait_cnt_r + 2'd1 : 2'd0;
            if (set_addr_s) begin
                ptr_r <= addr_f_s;
                sel_r <= sel_f_s;
            end else if (ptr_inc_s) begin
                ptr_r <= ptr_r + addr_width'(1);
                sel_r <= sel_r;
            end else begin
                ptr_r <= ptr_r;
                sel_r <= sel_r;
            end
            if (flag_clr_s) begin
                err_r  <= 1'b0;
                wrap_r <= 1'b0;
            end else begin
                err_r  <= err_r | err_set_s;
                wrap_r <= wrap_r | (ptr_inc_s & (&ptr_r));
            end
            if (rd_issue_s) begin
                rd_valid_r <= 1'b0;
                rd_data_r  <= rd_data_r;
            end else if (rd_done_s) begin
                rd_valid_r <= 1'b1;
                rd_data_r  <= sel_rdata_s;
            end else begin
                rd_valid_r <= rd_valid_r;
                rd_data_r  <= rd_data_r;
            end
            we_r      <= (state_nxt_s == WR_STB) ? sel_onehot_s : '0;
            re_r      <= (state_nxt_s == RD_STB) ? sel_onehot_s : '0;
            mux_sel_r <= (state_nxt_s != IDLE);
            busy_r    <= (state_nxt_s != IDLE);
        end
    end
endmodule

// File: tb/tb_as_jtag_mem_loader.sv
// Scoreboard bench: randomized DR scans checked against a transaction-level model of the loader.
`timescale 1ns/1ps
module tb_as_jtag_mem_loader;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int NT  = 3;
    localparam int LAT = 2;
    localparam int SW  = (NT > 1) ? $clog2(NT) : 1;
    localparam int CL  = 2 + SW + AW + DW;
    localparam int DEPTH = 1 << AW;

    logic tck = 1'b0, tap_rst_s = 1'b1;
    logic dr_shift = 1'b0, dr_clock = 1'b0, dr_upd = 1'b0, ser_i = 1'b0;
    logic ser_o, busy;

    as_jtag_mem_loader_if #(.addr_width(AW), .data_width(DW), .nr_targets(NT)) mif();

    as_jtag_mem_loader #(.addr_width(AW), .data_width(DW), .nr_targets(NT), .rd_latency(LAT)) dut (
        .tck_i(tck), .tap_rst_s(tap_rst_s), .dr_shift_i(dr_shift), .dr_clock_i(dr_clock),
        .dr_upd_i(dr_upd), .ser_i(ser_i), .ser_o(ser_o), .busy_o(busy), .mem(mif)
    );

    always #5 tck = ~tck;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [31:0] init_val(input int t, input int a);
        return 32'h1357_9BDF ^ (32'(t) * 32'h0101_0101) ^ (32'(a) * 32'h0001_0003);
    endfunction

    // ---------------- target memories (slave side) ----------------
    logic [DW-1:0] smem  [NT*DEPTH];
    bit            swr   [NT*DEPTH];
    int            rd_age, rd_tgt;
    logic [AW-1:0] rd_addr;

    always @(posedge tck or posedge tap_rst_s) begin
        if (tap_rst_s) begin
            rd_age <= 0;
        end else begin
            for (int k = 0; k < NT; k++) begin
                if (mif.mem_we_o[k]) begin
                    smem[k*DEPTH + int'(mif.mem_addr_o)] <= mif.mem_wdata_o;
                    swr[k*DEPTH + int'(mif.mem_addr_o)]  <= 1'b1;
                end
            end
            if (mif.mem_re_o != '0) begin
                rd_age  <= 1;
                rd_addr <= mif.mem_addr_o;
                for (int k = 0; k < NT; k++) if (mif.mem_re_o[k]) rd_tgt <= k;
            end else if (rd_age != 0) begin
                rd_age <= rd_age + 1;
            end
        end
    end

    // Read data is only valid in exactly the rd_latency-th cycle after the strobe.
    always @* begin
        int idx;
        mif.mem_rdata_i = {NT{32'hDEAD_0BAD}};
        idx = rd_tgt * DEPTH + int'(rd_addr);
        if (rd_age == LAT)
            mif.mem_rdata_i[rd_tgt*DW +: DW] = swr[idx] ? smem[idx] : init_val(rd_tgt, int'(rd_addr));
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [NT-1:0] stb;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;

    acc_t        wr_q[$], rd_q[$];
    int          mux_q[$];
    logic [63:0] exp_cap_q[$], got_cap_q[$];

    int            m_ptr, m_sel;
    bit            m_err, m_wrap, m_rv;
    logic [DW-1:0] m_rd;
    logic [DW-1:0] mmem [NT*DEPTH];

    task automatic model_reset();
        m_ptr = 0; m_sel = 0; m_err = 0; m_wrap = 0; m_rv = 0; m_rd = '0;
    endtask

    task automatic advance();
        if (m_ptr == DEPTH - 1) m_wrap = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
    endtask

    function automatic logic [63:0] model_cap();
        int sf;
        sf = m_sel;
        if (SW > 1) sf = (int'(m_wrap) << (SW - 1)) | (m_sel % (1 << (SW - 1)));
        return (64'(m_rd) << (2 + SW + AW)) | (64'(m_ptr) << (2 + SW)) | (64'(sf) << 2)
             | (64'(m_err) << 1) | 64'(m_rv);
    endfunction

    task automatic model_apply(input int cmd, input int sel, input int addr, input logic [31:0] data);
        acc_t e;
        case (cmd)
            0: begin m_err = 0; m_wrap = 0; end
            1: begin
                if (sel < NT) begin m_ptr = addr; m_sel = sel; end
                else m_err = 1;
            end
            2: begin
                e.stb = NT'(1) << m_sel; e.a = AW'(m_ptr); e.d = data;
                wr_q.push_back(e);
                mmem[m_sel*DEPTH + m_ptr] = data;
                mux_q.push_back(1);
                advance();
            end
            default: begin
                e.stb = NT'(1) << m_sel; e.a = AW'(m_ptr); e.d = '0;
                rd_q.push_back(e);
                m_rd = mmem[m_sel*DEPTH + m_ptr];
                m_rv = 1;
                mux_q.push_back(1 + LAT);
                advance();
            end
        endcase
    endtask

    // ---------------- monitor ----------------
    int mux_run = 0;
    always @(negedge tck) begin
        acc_t e;
        if (tap_rst_s) begin
            mux_run <= 0;
        end else begin
            if (mif.mem_we_o != '0) begin
                if (wr_q.size() == 0) chk("unexpected_write", 64'(mif.mem_we_o), 64'd0);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_strobe", 64'(mif.mem_we_o), 64'(e.stb));
                    chk("wr_addr", 64'(mif.mem_addr_o), 64'(e.a));
                    chk("wr_data", 64'(mif.mem_wdata_o), 64'(e.d));
                end
            end
            if (mif.mem_re_o != '0) begin
                if (rd_q.size() == 0) chk("unexpected_read", 64'(mif.mem_re_o), 64'd0);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_strobe", 64'(mif.mem_re_o), 64'(e.stb));
                    chk("rd_addr", 64'(mif.mem_addr_o), 64'(e.a));
                end
            end
            if (mif.mux_sel_o) begin
                mux_run <= mux_run + 1;
            end else if (mux_run != 0) begin
                if (mux_q.size() == 0) chk("unexpected_mux", 64'(mux_run), 64'd0);
                else chk("mux_len", 64'(mux_run), 64'(mux_q.pop_front()));
                mux_run <= 0;
            end
            if (got_cap_q.size() != 0 && exp_cap_q.size() != 0)
                chk("capture", got_cap_q.pop_front(), exp_cap_q.pop_front());
        end
    end

    // ---------------- driver ----------------
    function automatic logic [63:0] build(input int cmd, input int sel, input int addr, input logic [31:0] data);
        return (64'(data) << (2 + SW + AW)) | (64'(addr % DEPTH) << (2 + SW))
             | (64'(sel % (1 << SW)) << 2) | 64'(cmd % 4);
    endfunction

    task automatic scan_shift(input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        @(negedge tck); dr_clock = 1'b1; dr_shift = 1'b0;
        @(negedge tck); dr_shift = 1'b1;
        for (int k = 0; k < CL; k++) begin
            dout[k] = ser_o;
            ser_i   = din[k];
            @(negedge tck);
        end
        dr_clock = 1'b0; dr_shift = 1'b0;
    endtask

    task automatic upd_pulse(input int n);
        dr_upd = 1'b1;
        repeat (n) @(negedge tck);
        dr_upd = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge tck);
        while (busy && n < 40) begin @(negedge tck); n++; end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic issue(input int cmd, input int sel, input int addr, input logic [31:0] data, input int upd);
        logic [63:0] dout;
        exp_cap_q.push_back(model_cap());
        model_apply(cmd, sel, addr, data);
        scan_shift(build(cmd, sel, addr, data), dout);
        got_cap_q.push_back(dout);
        upd_pulse(upd);
        wait_idle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ser_o"}, 64'(ser_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_mux_sel"}, 64'(mif.mux_sel_o), 64'd0);
        chk({tag, "_we"}, 64'(mif.mem_we_o), 64'd0);
        chk({tag, "_re"}, 64'(mif.mem_re_o), 64'd0);
        chk({tag, "_addr"}, 64'(mif.mem_addr_o), 64'd0);
        chk({tag, "_wdata"}, 64'(mif.mem_wdata_o), 64'd0);
    endtask

    initial begin
        logic [63:0] dout;
        for (int i = 0; i < NT*DEPTH; i++) mmem[i] = init_val(i / DEPTH, i % DEPTH);
        model_reset();

        repeat (3) @(negedge tck);
        chk_all_zero("por");
        tap_rst_s = 1'b0;
        @(negedge tck);

        // pointer wrap on consecutive writes
        issue(1, 1, 'h3FE, 32'h0, 1);
        issue(2, 0, 0, 32'hDEAD_BEEF, 1);
        issue(2, 0, 0, 32'hDEAD_BEEF, 1);

        // write then read back through TDO
        issue(1, 0, 'h010, 32'h0, 1);
        issue(2, 0, 0, 32'hCAFE_F00D, 1);
        issue(1, 0, 'h010, 32'h0, 1);
        issue(3, 0, 0, 32'h0, 1);
        issue(0, 0, 0, 32'h0, 1);

        // update edge while the read is still waiting
        exp_cap_q.push_back(model_cap());
        model_apply(3, 0, 0, 32'h0);
        scan_shift(build(3, 0, 0, 32'h0), dout);
        got_cap_q.push_back(dout);
        upd_pulse(1);
        @(negedge tck);
        upd_pulse(1);
        m_err = 1;
        wait_idle();
        issue(0, 0, 0, 32'h0, 1);
        issue(0, 0, 0, 32'h0, 1);

        // out-of-range select, then held update level
        issue(1, 3, 'h155, 32'h0, 1);
        issue(0, 0, 0, 32'h0, 1);
        issue(2, 0, 0, 32'h0BAD_CAFE, 5);

        for (int it = 0; it < 40; it++) begin
            int c, s, a;
            c = $urandom_range(0, 3);
            s = $urandom_range(0, 3);
            a = ($urandom_range(0, 3) == 0) ? (DEPTH - 4 + $urandom_range(0, 3)) : $urandom_range(0, DEPTH - 1);
            issue(c, s, a, $urandom, $urandom_range(1, 5));
        end

        // async reset in the middle of a write strobe
        exp_cap_q.push_back(model_cap());
        scan_shift(build(2, 0, 0, 32'h1234_5678), dout);
        got_cap_q.push_back(dout);
        dr_upd = 1'b1;
        @(posedge tck); #2;
        chk("pre_reset_we", 64'(mif.mem_we_o), 64'(NT'(1) << m_sel));
        tap_rst_s = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(negedge tck); dr_upd = 1'b0;
        @(negedge tck); tap_rst_s = 1'b0;
        model_reset();
        issue(0, 0, 0, 32'h0, 1);
        issue(0, 0, 0, 32'h0, 1);

        repeat (5) @(negedge tck);
        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        chk("mux_q_empty", 64'(mux_q.size()), 64'd0);
        chk("cap_q_empty", 64'(exp_cap_q.size() + got_cap_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
